// File: rtl/booth_mult_seq_if.sv
// Handshake and operand/result bundle for the sequential Booth multiplier.
interface booth_mult_seq_if #(
  parameter int unsigned WIDTH = 4
);
  logic                   start;
  logic [WIDTH-1:0]       multiplicand;
  logic [WIDTH-1:0]       multiplier;
  logic                   busy;
  logic                   done;
  logic [2*WIDTH-1:0]     product;

  modport master (
    output start, multiplicand, multiplier,
    input  busy, done, product
  );

  modport slave (
    input  start, multiplicand, multiplier,
    output busy, done, product
  );
endinterface

// File: rtl/booth_mult_seq.sv
// Sequential signed radix-2 Booth multiplier: one add/sub/no-op plus arithmetic
// shift per cycle, WIDTH iterations, 2*WIDTH-bit registered product.
module booth_mult_seq #(
  parameter int unsigned WIDTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  booth_mult_seq_if.slave   bus
);

  localparam int unsigned AW = WIDTH + 1;
  localparam int unsigned CW = $clog2(WIDTH + 1);
  localparam int unsigned PW = 2 * WIDTH;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   a_q, a_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic            q1_q, q1_d;
  logic [AW-1:0]   m_q, m_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [PW-1:0]   product_d;
  logic            busy_d, done_d;
  logic [AW-1:0]   addsub;

  // State and datapath registers; reset overrides everything
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      a_q         <= '0;
      q_q         <= '0;
      q1_q        <= 1'b0;
      m_q         <= '0;
      cnt_q       <= '0;
      bus.busy    <= 1'b0;
      bus.done    <= 1'b0;
      bus.product <= '0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      q_q         <= q_d;
      q1_q        <= q1_d;
      m_q         <= m_d;
      cnt_q       <= cnt_d;
      bus.busy    <= busy_d;
      bus.done    <= done_d;
      bus.product <= product_d;
    end
  end

  // Next-state and next-datapath logic
  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    q_d       = q_q;
    q1_d      = q1_q;
    m_d       = m_q;
    cnt_d     = cnt_q;
    product_d = bus.product;
    addsub    = a_q;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          a_d     = '0;
          q_d     = bus.multiplier;
          q1_d    = 1'b0;
          m_d     = {bus.multiplicand[WIDTH-1], bus.multiplicand};
          cnt_d   = CW'(WIDTH);
          state_d = RUN;
        end
      end
      RUN: begin
        case ({q_q[0], q1_q})
          2'b10:   addsub = a_q + ~m_q + AW'(1);
          2'b01:   addsub = a_q + m_q;
          default: addsub = a_q;
        endcase
        // Arithmetic shift of {A', Q, Q_1}
        a_d   = {addsub[AW-1], addsub[AW-1:1]};
        q_d   = {addsub[0], q_q[WIDTH-1:1]};
        q1_d  = q_q[0];
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          product_d = {a_d[WIDTH-1:0], q_d};
          state_d   = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

endmodule

// File: tb/tb_booth_mult_seq.sv
// Self-checking bench for booth_mult_seq: timeline model of busy/done/product
// checked every cycle, plus directed literal cases and randomized traffic.
module tb_booth_mult_seq;

  localparam int unsigned W  = 4;
  localparam int unsigned PW = 2 * W;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  booth_mult_seq_if #(.WIDTH(W)) bus ();

  booth_mult_seq #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  // Reference model: transaction timeline, result from integer multiplication
  bit            m_busy = 1'b0;
  bit            m_done = 1'b0;
  logic [PW-1:0] m_prod = '0;
  logic [PW-1:0] m_res  = '0;
  int            m_phase = 0;

  function automatic logic [PW-1:0] ref_mul(input logic [W-1:0] a, input logic [W-1:0] b);
    int sa;
    int sb;
    sa = int'($signed(a));
    sb = int'($signed(b));
    return PW'(sa * sb);
  endfunction

  always @(posedge clk) begin
    if (reset === 1'b1) begin
      m_busy  = 1'b0;
      m_done  = 1'b0;
      m_prod  = '0;
      m_phase = 0;
    end else if (!m_busy) begin
      if (bus.start === 1'b1) begin
        m_busy  = 1'b1;
        m_phase = 0;
        m_res   = ref_mul(bus.multiplicand, bus.multiplier);
      end
    end else begin
      m_phase++;
      if (m_phase == W) begin
        m_done = 1'b1;
        m_prod = m_res;
      end else if (m_phase == W + 1) begin
        m_busy = 1'b0;
        m_done = 1'b0;
      end
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("model_busy", 64'(bus.busy), 64'(m_busy));
      check("model_done", 64'(bus.done), 64'(m_done));
      check("model_product", 64'(bus.product), 64'(m_prod));
    end
  end

  // One transaction; expects the caller to leave the DUT idle
  task automatic run_op(input logic [W-1:0] mc, input logic [W-1:0] mp,
                        input logic [PW-1:0] exp, input string name);
    int n;
    bit seen;
    @(negedge clk);
    bus.start        = 1'b1;
    bus.multiplicand = mc;
    bus.multiplier   = mp;
    @(negedge clk);
    bus.start        = 1'b0;
    bus.multiplicand = W'($urandom);
    bus.multiplier   = W'($urandom);
    n    = 1;
    seen = 1'b0;
    while (!seen && n <= 3 * W) begin
      if (bus.done === 1'b1) seen = 1'b1;
      else begin
        @(negedge clk);
        n++;
      end
    end
    check({name, "_done_seen"}, 64'(seen), 64'(1));
    if (seen) begin
      check({name, "_latency"}, 64'(n), 64'(W + 1));
      check(name, 64'(bus.product), 64'(exp));
    end
    @(negedge clk);
    check({name, "_busy_low"}, 64'(bus.busy), 64'(0));
  endtask

  task automatic lit_op(input logic [W-1:0] mc, input logic [W-1:0] mp,
                        input logic [PW-1:0] lit, input string name);
    check({"ref_", name}, 64'(ref_mul(mc, mp)), 64'(lit));
    run_op(mc, mp, lit, name);
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (bus.busy !== 1'b0 && n < 4 * W) begin
      @(negedge clk);
      n++;
    end
    check({name, "_idle"}, 64'(bus.busy), 64'(0));
  endtask

  initial begin
    int dones;
    reset            = 1'b1;
    bus.start        = 1'b0;
    bus.multiplicand = '0;
    bus.multiplier   = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check("rst_busy", 64'(bus.busy), 64'(0));
    check("rst_done", 64'(bus.done), 64'(0));
    check("rst_product", 64'(bus.product), 64'(8'h00));
    chk_en = 1'b1;

    dones = 0;
    repeat (10) begin
      @(negedge clk);
      if (bus.done === 1'b1) dones++;
    end
    check("idle_no_done", 64'(dones), 64'(0));

    lit_op(4'b0011, 4'b0101, 8'h0F, "basic_3x5");
    lit_op(4'b1000, 4'b1000, 8'h40, "m8xm8");
    lit_op(4'b0111, 4'b1000, 8'hC8, "7xm8");
    lit_op(4'b1111, 4'b0001, 8'hFF, "m1x1");
    lit_op(4'b0000, 4'b1011, 8'h00, "0xm5");

    // start held high: one result every W+2 cycles
    @(negedge clk);
    bus.start        = 1'b1;
    bus.multiplicand = 4'd2;
    bus.multiplier   = 4'd3;
    dones = 0;
    repeat (3 * (W + 2)) begin
      @(negedge clk);
      if (bus.done === 1'b1) begin
        dones++;
        check("held_product", 64'(bus.product), 64'(8'h06));
      end
    end
    bus.start = 1'b0;
    check("held_done_count", 64'(dones), 64'(3));
    wait_idle("held");

    // Reset on the second RUN edge aborts the operation
    @(negedge clk);
    bus.start        = 1'b1;
    bus.multiplicand = 4'd5;
    bus.multiplier   = 4'd5;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort_busy", 64'(bus.busy), 64'(0));
    check("abort_product", 64'(bus.product), 64'(8'h00));
    dones = 0;
    repeat (10) begin
      @(negedge clk);
      if (bus.done === 1'b1) dones++;
    end
    check("abort_no_done", 64'(dones), 64'(0));
    lit_op(4'b1101, 4'b0110, 8'hEE, "m3x6");

    // Exhaustive operand pairs
    for (int i = 0; i < (1 << W); i++) begin
      for (int j = 0; j < (1 << W); j++) begin
        run_op(W'(i), W'(j), ref_mul(W'(i), W'(j)), "exh");
      end
    end

    // Random start/operand/reset traffic against the per-cycle model
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      bus.start        = ($urandom_range(0, 2) == 0);
      bus.multiplicand = W'($urandom);
      bus.multiplier   = W'($urandom);
      reset            = ($urandom_range(0, 60) == 0);
    end
    @(negedge clk);
    bus.start = 1'b0;
    reset     = 1'b0;
    wait_idle("random");
    repeat (2) @(negedge clk);

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
